axi4l_master_bridge: RTL and testbench

- Converts the core's single-beat memory request interface (LSU or debug port) into AXI4-Lite master transactions toward slaves such as iram.
- Initiator end of the AXI4-Lite interface the memory slaves implement.
- One transaction outstanding at a time.
- A response timeout guards against hung slaves.

---
 rtl/axi4l_master_bridge_pkg.sv | 25 ++
 rtl/axi4l_master_bridge_if.sv | 41 ++++
 rtl/axi4l_master_bridge.sv | 197 +++++++++++++++++++
 tb/tb_axi4l_master_bridge.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_master_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite master bridge.
package axi4l_master_bridge_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_DRAIN   = 3'd5
  } mst_state_e;

  // Any non-OKAY response (SLVERR, DECERR, or anything unexpected) is an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4l_master_bridge_if.sv
// AXI4-Lite bus bundle between the bridge (master) and a memory slave.
interface axi4l_master_bridge_if;
  import axi4l_master_bridge_pkg::*;

  logic [MEM_ADDR_W-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [MEM_DATA_W-1:0] wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [MEM_ADDR_W-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [MEM_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi4l_master_bridge.sv
// Single-outstanding bridge from the core's memory request port to AXI4-Lite.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a request; the only state that grants
// WR_ADDR  | awvalid/wvalid offered together, each drops after its handshake
// WR_RESP  | bready high, waiting for the write response
// RD_ADDR  | arvalid high until arready
// RD_DATA  | rready high, waiting for read data
// DRAIN    | timed out: finish pending handshakes, swallow the late response
module axi4l_master_bridge
  import axi4l_master_bridge_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mst_req_i,
  input  logic                  mst_we_i,
  input  logic [MEM_ADDR_W-1:0] mst_addr_i,
  input  logic [MEM_DATA_W-1:0] mst_wdata_i,
  input  logic [3:0]            mst_wstrb_i,
  output logic                  mst_gnt_o,
  output logic                  mst_rsp_vld_o,
  output logic [MEM_DATA_W-1:0] mst_rdata_o,
  output logic                  mst_err_o,
  output logic                  busy_o,
  axi4l_master_bridge_if.master m_axi
);

  mst_state_e            state_q, state_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [MEM_DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  we_q, we_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  ar_done_q, ar_done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic                  err_q, err_d;
  logic [MEM_DATA_W-1:0] rdata_q, rdata_d;

  logic gnt, time_out, expire;
  logic wr_drain, rd_drain;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Bus-side valids/readies are pure decodes of registered state, so they
  // rise the cycle after grant and never glitch.
  assign wr_drain = (state_q == ST_DRAIN) && we_q;
  assign rd_drain = (state_q == ST_DRAIN) && !we_q;
  assign awvalid  = ((state_q == ST_WR_ADDR) || wr_drain) && !aw_done_q;
  assign wvalid   = ((state_q == ST_WR_ADDR) || wr_drain) && !w_done_q;
  assign bready   = (state_q == ST_WR_RESP) || (wr_drain && aw_done_q && w_done_q);
  assign arvalid  = ((state_q == ST_RD_ADDR) || rd_drain) && !ar_done_q;
  assign rready   = (state_q == ST_RD_DATA) || (rd_drain && ar_done_q);

  assign aw_hs = awvalid && m_axi.awready;
  assign w_hs  = wvalid && m_axi.wready;
  assign b_hs  = bready && m_axi.bvalid;
  assign ar_hs = arvalid && m_axi.arready;
  assign r_hs  = rready && m_axi.rvalid;

  // Counter value one below TIMEOUT means this cycle is the last one allowed.
  assign expire = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid;
  assign m_axi.bready  = bready;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid;
  assign m_axi.rready  = rready;

  assign mst_gnt_o     = gnt;
  assign mst_rsp_vld_o = rsp_vld_q;
  assign mst_rdata_o   = rdata_q;
  assign mst_err_o     = err_q;
  assign busy_o        = (state_q != ST_IDLE);

  // Next-state, request capture, timeout counting and response generation.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    we_d      = we_q;
    aw_done_d = aw_done_q || aw_hs;
    w_done_d  = w_done_q || w_hs;
    ar_done_d = ar_done_q || ar_hs;
    cnt_d     = cnt_q;
    rsp_vld_d = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    gnt       = 1'b0;
    time_out  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Holding off one cycle after a response keeps the core from
        // issuing in the same cycle it consumes the previous result.
        gnt = mst_req_i && !rsp_vld_q;
        if (gnt) begin
          addr_d    = mst_addr_i;
          wdata_d   = mst_wdata_i;
          wstrb_d   = mst_wstrb_i;
          we_d      = mst_we_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          ar_done_d = 1'b0;
          cnt_d     = '0;
          state_d   = mst_we_i ? ST_WR_ADDR : ST_RD_ADDR;
        end
      end
      ST_WR_ADDR: begin
        cnt_d = cnt_q + 1'b1;
        if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
        else                       time_out = expire;
      end
      ST_WR_RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (b_hs) begin
          rsp_vld_d = 1'b1;
          err_d     = resp_is_err(m_axi.bresp);
          state_d   = ST_IDLE;
        end else begin
          time_out = expire;
        end
      end
      ST_RD_ADDR: begin
        cnt_d = cnt_q + 1'b1;
        if (ar_hs) state_d = ST_RD_DATA;
        else       time_out = expire;
      end
      ST_RD_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (r_hs) begin
          rsp_vld_d = 1'b1;
          err_d     = resp_is_err(m_axi.rresp);
          rdata_d   = m_axi.rdata;
          state_d   = ST_IDLE;
        end else begin
          time_out = expire;
        end
      end
      ST_DRAIN: begin
        if (b_hs || r_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (time_out) begin
      rsp_vld_d = 1'b1;
      err_d     = 1'b1;
      rdata_d   = '0;
      state_d   = ST_DRAIN;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ar_done_q <= 1'b0;
      cnt_q     <= '0;
      rsp_vld_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      we_q      <= we_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ar_done_q <= ar_done_d;
      cnt_q     <= cnt_d;
      rsp_vld_q <= rsp_vld_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi4l_master_bridge.sv
// Self-checking bench for axi4l_master_bridge with a small AXI4-Lite slave model.
module tb_axi4l_master_bridge;
  import axi4l_master_bridge_pkg::*;

  localparam int TO = 8;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mst_req_i = 1'b0;
  logic        mst_we_i = 1'b0;
  logic [31:0] mst_addr_i = '0;
  logic [31:0] mst_wdata_i = '0;
  logic [3:0]  mst_wstrb_i = '0;
  logic        mst_gnt_o, mst_rsp_vld_o, mst_err_o, busy_o;
  logic [31:0] mst_rdata_o;

  axi4l_master_bridge_if axi ();

  axi4l_master_bridge #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mst_req_i    (mst_req_i),
    .mst_we_i     (mst_we_i),
    .mst_addr_i   (mst_addr_i),
    .mst_wdata_i  (mst_wdata_i),
    .mst_wstrb_i  (mst_wstrb_i),
    .mst_gnt_o    (mst_gnt_o),
    .mst_rsp_vld_o(mst_rsp_vld_o),
    .mst_rdata_o  (mst_rdata_o),
    .mst_err_o    (mst_err_o),
    .busy_o       (busy_o),
    .m_axi        (axi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic        split_mode = 1'b0;
  logic        aw_block = 1'b0;
  logic        rd_hang = 1'b0;
  logic        late_rv = 1'b0;
  logic [31:0] late_data = '0;
  logic [1:0]  sl_bresp = RESP_OKAY;
  logic [1:0]  sl_rresp = RESP_OKAY;
  logic        w_seen = 1'b0;
  int          split_cnt = 0;
  logic        rv_q = 1'b0;
  logic [31:0] rd_q = '0;
  logic [1:0]  rr_q = RESP_OKAY;
  logic [31:0] mem [16] = '{default: '0};
  logic        wa_v = 1'b0, wd_v = 1'b0;
  logic [31:0] wa = '0, wd = '0;
  logic        sl_aw_hs, sl_w_hs;

  assign axi.wready  = !aw_block && (split_mode ? axi.wvalid : (axi.awvalid && axi.wvalid));
  assign axi.awready = !aw_block && (split_mode ? (axi.awvalid && w_seen && split_cnt == 2)
                                                : (axi.awvalid && axi.wvalid));
  assign axi.bvalid  = 1'b1;
  assign axi.bresp   = sl_bresp;
  assign axi.arready = axi.arvalid;
  assign axi.rvalid  = rv_q | late_rv;
  assign axi.rdata   = late_rv ? late_data : rd_q;
  assign axi.rresp   = late_rv ? RESP_OKAY : rr_q;
  assign sl_aw_hs    = axi.awvalid && axi.awready;
  assign sl_w_hs     = axi.wvalid && axi.wready;

  // Split mode: awready comes 3 cycles after the write-data handshake.
  always @(posedge clk) begin
    if (!split_mode || sl_aw_hs) begin
      w_seen    <= 1'b0;
      split_cnt <= 0;
    end else begin
      if (sl_w_hs) w_seen <= 1'b1;
      if (w_seen)  split_cnt <= split_cnt + 1;
    end
  end

  // Write commit once both address and data have been accepted.
  always @(posedge clk) begin
    if ((wa_v || sl_aw_hs) && (wd_v || sl_w_hs)) begin
      mem[sl_aw_hs ? axi.awaddr[5:2] : wa[5:2]] <= sl_w_hs ? axi.wdata : wd;
      wa_v <= 1'b0;
      wd_v <= 1'b0;
    end else begin
      if (sl_aw_hs) begin wa_v <= 1'b1; wa <= axi.awaddr; end
      if (sl_w_hs)  begin wd_v <= 1'b1; wd <= axi.wdata;  end
    end
  end

  // Read data one cycle after the address handshake (unless hung).
  always @(posedge clk) begin
    if (axi.arvalid && axi.arready && !rd_hang) begin
      rv_q <= 1'b1;
      rd_q <= mem[axi.araddr[5:2]];
      rr_q <= sl_rresp;
    end else if (axi.rvalid && axi.rready) begin
      rv_q <= 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int gnt_cyc = -1, aw_first = -1, w_first = -1, ar_first = -1;
  int aw_hs_cyc = -1, w_hs_cyc = -1, ar_hs_cyc = -1;
  int aw_hs_n = 0, w_hs_n = 0, aw_after = 0, w_after = 0;
  int rsp_cyc = -1, rsp_cnt = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mst_gnt_o) begin
          gnt_cyc = cyc; aw_first = -1; w_first = -1; ar_first = -1;
          aw_hs_cyc = -1; w_hs_cyc = -1; ar_hs_cyc = -1;
          aw_hs_n = 0; w_hs_n = 0; aw_after = 0; w_after = 0;
        end
        if (axi.awvalid && aw_first < 0) aw_first = cyc;
        if (axi.wvalid && w_first < 0)   w_first = cyc;
        if (axi.arvalid && ar_first < 0) ar_first = cyc;
        if (axi.awvalid && aw_hs_n > 0)  aw_after++;
        if (axi.wvalid && w_hs_n > 0)    w_after++;
        if (sl_aw_hs) begin aw_hs_n++; aw_hs_cyc = cyc; end
        if (sl_w_hs)  begin w_hs_n++;  w_hs_cyc = cyc;  end
        if (axi.arvalid && axi.arready) ar_hs_cyc = cyc;
        if (mst_rsp_vld_o) begin
          rsp_cnt++;
          rsp_cyc = cyc;
          check("rsp_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_err", mst_err_o, e.err);
            check("rsp_rdata", mst_rdata_o, e.rdata);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic exp_err, input logic [31:0] exp_rdata);
    int k;
    exp_t e;
    @(posedge clk); #1;
    mst_req_i = 1'b1; mst_we_i = we; mst_addr_i = addr;
    mst_wdata_i = wdata; mst_wstrb_i = strb;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!mst_gnt_o && k < 20);
    check("grant_seen", mst_gnt_o, 1);
    e.err = exp_err;
    e.rdata = exp_rdata;
    exp_q.push_back(e);
    @(posedge clk); #1;
    mst_req_i = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input string tag);
    int k = 0;
    while (rsp_cnt < target && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    check({tag, "_rsp_seen"}, rsp_cnt >= target, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic gnt_seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", mst_gnt_o, 0);
    check("rst_rsp_vld", mst_rsp_vld_o, 0);
    check("rst_err", mst_err_o, 0);
    check("rst_rdata", mst_rdata_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_awvalid", axi.awvalid, 0);
    check("rst_wvalid", axi.wvalid, 0);
    check("rst_arvalid", axi.arvalid, 0);
    check("rst_bready", axi.bready, 0);
    check("rst_rready", axi.rready, 0);
    check("rst_awaddr", axi.awaddr, 0);
    check("rst_awprot", axi.awprot, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: iram-like write
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    wait_rsp(1, "t1");
    check("t1_valid_after_gnt", aw_first - gnt_cyc, 1);
    check("t1_aw_w_together", aw_first, w_first);
    check("t1_aw_hs_n", aw_hs_n, 1);
    check("t1_hs_to_rsp", rsp_cyc - aw_hs_cyc, 2);
    check("t1_mem4", mem[4], 32'hDEADBEEF);

    // 2: split write handshake
    split_mode = 1'b1;
    issue(1'b1, 32'h14, 32'h12345678, 4'hF, 1'b0, 32'h0);
    wait_rsp(2, "t2");
    check("t2_aw_w_together", aw_first, w_first);
    check("t2_w_to_aw", aw_hs_cyc - w_hs_cyc, 3);
    check("t2_w_dropped", w_after, 0);
    check("t2_aw_dropped", aw_after, 0);
    check("t2_aw_hs_n", aw_hs_n, 1);
    split_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t2_single_rsp", rsp_cnt, 2);
    check("t2_mem5", mem[5], 32'h12345678);

    // 3: read back
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);
    wait_rsp(3, "t3");
    check("t3_ar_to_rsp", rsp_cyc - ar_hs_cyc, 2);
    @(negedge clk); #1;
    check("t3_busy_after", busy_o, 0);

    // 4: error responses
    sl_bresp = RESP_SLVERR;
    issue(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0);
    wait_rsp(4, "t4w");
    sl_bresp = RESP_OKAY;
    sl_rresp = RESP_DECERR;
    issue(1'b0, 32'h14, 32'h0, 4'h0, 1'b1, 32'h12345678);
    wait_rsp(5, "t4r");
    sl_rresp = RESP_OKAY;

    // 5: timeout, drain of a late response
    rd_hang = 1'b1;
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'h0);
    wait_rsp(6, "t5");
    check("t5_timeout_cycle", rsp_cyc - ar_first, TO);
    check("t5_busy_drain", busy_o, 1);
    @(posedge clk); #1;
    mst_req_i = 1'b1; mst_we_i = 1'b0; mst_addr_i = 32'h10;
    gnt_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      gnt_seen = gnt_seen | mst_gnt_o;
    end
    check("t5_gnt_withheld", gnt_seen, 0);
    @(posedge clk); #1;
    mst_req_i = 1'b0;
    late_data = 32'h0BAD0BAD;
    late_rv = 1'b1;
    @(posedge clk); #1;
    late_rv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_second_rsp", rsp_cnt, 6);
    check("t5_idle_after_drain", busy_o, 0);

    // 5b: response in the very cycle the timeout would fire
    late_data = 32'h600DF00D;
    issue(1'b0, 32'h14, 32'h0, 4'h0, 1'b0, 32'h600DF00D);
    repeat (7) @(posedge clk);
    #1;
    late_rv = 1'b1;
    @(posedge clk); #1;
    late_rv = 1'b0;
    wait_rsp(7, "t5b");
    check("t5b_rsp_cycle", rsp_cyc - ar_first, TO);
    repeat (2) @(posedge clk);
    #1;
    check("t5b_no_drain", busy_o, 0);
    check("t5b_single_rsp", rsp_cnt, 7);
    rd_hang = 1'b0;

    // 6: reset during WR_ADDR
    aw_block = 1'b1;
    issue(1'b1, 32'h30, 32'h11111111, 4'hF, 1'b0, 32'h0);
    #2;
    check("t6_awvalid_pre", axi.awvalid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_awvalid_rst", axi.awvalid, 0);
    check("t6_wvalid_rst", axi.wvalid, 0);
    check("t6_busy_rst", busy_o, 0);
    check("t6_rsp_vld_rst", mst_rsp_vld_o, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    aw_block = 1'b0;
    check("t6_no_rsp", rsp_cnt, 7);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);
    wait_rsp(8, "t6");
    repeat (2) @(posedge clk);
    #1;
    check("t6_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
